// File: rtl/bioz_sig_clkgen.sv
// bioz_sig_clkgen: quadrature (I/Q) excitation clock generator for the BioZ path.
// Optional 16-bit period counter output is enabled by defining BIOZ_CLKGEN_PCNT_EN.
module bioz_sig_clkgen #(
   parameter int BASE_QUARTER = 1,
   parameter int FSEL_MAX     = 11,
   parameter int CNT_W        = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  Fsel,
   input  logic        enable,
   output logic        clk_i,
   output logic        clk_q,
   output logic        period_tick,
   output logic [3:0]  fsel_active,
`ifdef BIOZ_CLKGEN_PCNT_EN
   output logic [15:0] period_count,
`endif
   output logic        running
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] qcnt_r;
   logic [1:0]       ph_r;
   logic [3:0]       fcur_r;
   logic             start_r;

   logic [3:0]       fs_eff_s;
   logic [CNT_W-1:0] qlast_s;
   logic             qend_s;
   logic             pend_s;

   // Last quarter-count value for a given frequency code (Q-1), computed wide to avoid overflow.
   function automatic logic [CNT_W-1:0] quarter_last(input logic [3:0] fs);
      logic [31:0] q;
      q = 32'(BASE_QUARTER) << fs;
      return CNT_W'(q - 32'd1);
   endfunction

   // Clamp the requested code and detect quarter / period ends.
   always_comb begin
      if (Fsel > 4'(FSEL_MAX)) begin
         fs_eff_s = 4'(FSEL_MAX);
      end else begin
         fs_eff_s = Fsel;
      end
      qlast_s = quarter_last(fcur_r);
      qend_s  = (qcnt_r == qlast_s);
      pend_s  = qend_s && (ph_r == 2'd3);
   end

   // Phase sequencer: period boundaries are the only place frequency and run/stop change.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         qcnt_r  <= '0;
         ph_r    <= 2'd0;
         fcur_r  <= 4'd0;
         start_r <= 1'b0;
      end else begin
         start_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (enable) begin
                  state_r <= ST_RUN;
                  qcnt_r  <= '0;
                  ph_r    <= 2'd0;
                  fcur_r  <= fs_eff_s;
                  start_r <= 1'b1;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (qend_s) begin
                  qcnt_r <= '0;
                  ph_r   <= ph_r + 2'd1;
               end else begin
                  qcnt_r <= qcnt_r + CNT_W'(1);
               end
               // Only a draining period that ends with enable still low returns to IDLE.
               if (pend_s && (state_r == ST_DRAIN) && !enable) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= enable ? ST_RUN : ST_DRAIN;
                  if (pend_s) begin
                     fcur_r  <= fs_eff_s;
                     start_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               qcnt_r  <= '0;
               ph_r    <= 2'd0;
            end
         endcase
      end
   end

   // Registered output decode of the sequencer state.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_i       <= 1'b0;
         clk_q       <= 1'b0;
         period_tick <= 1'b0;
         fsel_active <= 4'd0;
         running     <= 1'b0;
      end else begin
         if (state_r == ST_IDLE) begin
            clk_i       <= 1'b0;
            clk_q       <= 1'b0;
            fsel_active <= 4'd0;
            running     <= 1'b0;
         end else begin
            clk_i       <= ~ph_r[1];
            clk_q       <= ph_r[0] ^ ph_r[1];
            fsel_active <= fcur_r;
            running     <= 1'b1;
         end
         period_tick <= start_r;
      end
   end

`ifdef BIOZ_CLKGEN_PCNT_EN
   // Period counter: the first tick after a stopped output restarts it at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_count <= 16'd0;
      end else if (start_r) begin
         period_count <= running ? (period_count + 16'd1) : 16'd0;
      end else begin
         period_count <= period_count;
      end
   end
`endif

endmodule

// File: tb/tb_bioz_sig_clkgen.sv
// Self-checking bench for bioz_sig_clkgen: per-cycle period-position model plus
// directed literal checks on latency, period lengths, clamping, drain and reset.
module tb_bioz_sig_clkgen;
   localparam int BQ   = 1;
   localparam int FMAX = 11;
   localparam int CW   = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] Fsel = 4'd0;
   logic       clk_i, clk_q, period_tick, running;
   logic [3:0] fsel_active;
`ifdef BIOZ_CLKGEN_PCNT_EN
   logic [15:0] period_count;
`endif

   int checks = 0;
   int errors = 0;
   bit saw_low = 1'b0;

   always #5 clk = ~clk;

   bioz_sig_clkgen #(.BASE_QUARTER(BQ), .FSEL_MAX(FMAX), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .Fsel(Fsel), .enable(enable),
      .clk_i(clk_i), .clk_q(clk_q), .period_tick(period_tick),
      .fsel_active(fsel_active),
`ifdef BIOZ_CLKGEN_PCNT_EN
      .period_count(period_count),
`endif
      .running(running)
   );

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Model: a virtual period position t in 0..4Q-1; outputs follow one cycle behind.
   bit v_act = 0, v_run = 0, v_first = 0, model_ok = 0;
   int v_t = 0, v_q = BQ, v_fs = 0;
   bit e_i = 0, e_q = 0, e_tick = 0, e_run = 0;
   int e_fs = 0, e_pc = 0;

   always @(posedge clk) begin
      if (rst) begin
         v_act = 0; v_run = 0; v_first = 0; v_t = 0; v_q = BQ; v_fs = 0;
         e_i = 0; e_q = 0; e_tick = 0; e_run = 0; e_fs = 0; e_pc = 0;
         model_ok = 1;
      end else begin
         e_run  = v_act;
         e_tick = v_act && (v_t == 0);
         e_i    = v_act && (v_t < 2 * v_q);
         e_q    = v_act && (v_t >= v_q) && (v_t < 3 * v_q);
         e_fs   = v_act ? v_fs : 0;
         if (e_tick) e_pc = v_first ? 0 : (e_pc + 1) % 65536;
         if (!v_act) begin
            if (enable) begin
               v_act = 1; v_run = 1; v_first = 1;
               v_fs = (int'(Fsel) > FMAX) ? FMAX : int'(Fsel);
               v_q = BQ << v_fs; v_t = 0;
            end
         end else if (v_t == 4 * v_q - 1) begin
            if (v_run || enable) begin
               v_run = enable; v_first = 0;
               v_fs = (int'(Fsel) > FMAX) ? FMAX : int'(Fsel);
               v_q = BQ << v_fs; v_t = 0;
            end else begin
               v_act = 0;
            end
         end else begin
            v_t++;
            v_run = enable;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("m_clk_i", int'(clk_i), int'(e_i));
         chk("m_clk_q", int'(clk_q), int'(e_q));
         chk("m_tick", int'(period_tick), int'(e_tick));
         chk("m_running", int'(running), int'(e_run));
         chk("m_fsel_active", int'(fsel_active), e_fs);
`ifdef BIOZ_CLKGEN_PCNT_EN
         chk("m_period_count", int'(period_count), e_pc);
`endif
      end
   end

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!running) saw_low = 1'b1;
      end while (!period_tick && n < 20000);
      if (!period_tick) chk("tick_timeout", n, -1);
   endtask

   task automatic wait_stop(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (running && n < 100);
      if (running) chk("stop_timeout", n, -1);
   endtask

   initial begin
      int n;
      logic [3:0] pi, pq;
      repeat (3) @(negedge clk);
      chk("rst_clk_i", int'(clk_i), 0);
      chk("rst_clk_q", int'(clk_q), 0);
      chk("rst_tick", int'(period_tick), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_fsel", int'(fsel_active), 0);
      rst = 1'b0;
      @(negedge clk);

      // Start latency and Fsel=0 waveform
      enable = 1'b1; Fsel = 4'd0;
      @(negedge clk);
      chk("lat_early_clk_i", int'(clk_i), 0);
      @(negedge clk);
      chk("lat_clk_i", int'(clk_i), 1);
      chk("lat_tick", int'(period_tick), 1);
      chk("lat_running", int'(running), 1);
      for (int k = 3; k >= 0; k--) begin
         pi[k] = clk_i;
         pq[k] = clk_q;
         if (k > 0) @(negedge clk);
      end
      chk("pat_i", int'(pi), 4'b1100);
      chk("pat_q", int'(pq), 4'b0110);
      wait_tick(n);
      wait_tick(n);
      chk("period_fs0", n, 4);

      // Mid-period Fsel change waits for the boundary
      Fsel = 4'd3;
      wait_tick(n);
      chk("fsel_3", int'(fsel_active), 3);
      repeat (16) @(negedge clk);
      Fsel = 4'd1;
      wait_tick(n);
      chk("period_fs3", n + 16, 32);
      chk("fsel_1", int'(fsel_active), 1);

      // Clamp 15 -> 11
      Fsel = 4'd15;
      wait_tick(n);
      chk("period_fs1", n, 8);
      chk("fsel_clamp", int'(fsel_active), 11);
      Fsel = 4'd2;
      wait_tick(n);
      chk("period_fs11", n, 8192);
      chk("fsel_2", int'(fsel_active), 2);

      // Stop 5 cycles into a 16-cycle period
      repeat (5) @(negedge clk);
      enable = 1'b0;
      wait_stop(n);
      chk("drain_len", n, 11);
      chk("stop_clk_i", int'(clk_i), 0);
      chk("stop_clk_q", int'(clk_q), 0);

      // Re-raise enable during drain: no gap
      enable = 1'b1;
      wait_tick(n);
      saw_low = 1'b0;
      repeat (5) @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      wait_tick(n);
      chk("redrain_len", n, 8);
      chk("no_gap", int'(saw_low), 0);

      // Reset during clk_i high phase
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_clk_i", int'(clk_i), 0);
      chk("mid_rst_running", int'(running), 0);
      chk("mid_rst_fsel", int'(fsel_active), 0);
      rst = 1'b0;
      wait_tick(n);
      Fsel = 4'd0;
      wait_tick(n);
      chk("restart_period", n, 16);

      // Stop request at the boundary in RUN: one full extra period
      repeat (2) @(negedge clk);
      enable = 1'b0;
      wait_stop(n);
      chk("boundary_stop_len", n, 6);

`ifdef BIOZ_CLKGEN_PCNT_EN
      enable = 1'b1;
      wait_tick(n);
      repeat (9) wait_tick(n);
      chk("pcnt_9", int'(period_count), 9);
      enable = 1'b0;
      wait_stop(n);
      enable = 1'b1;
      wait_tick(n);
      chk("pcnt_restart", int'(period_count), 0);
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
